// File: rtl/sc_mem_sequencer.sv
// Multi-cycle sequencer sharing one memory port between instruction fetch and
// load/store data access, with run/step control, retire counter and bus timeout.
module sc_mem_sequencer #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step,
    input  logic [DBITS-1:0]    pcOut,
    input  logic                isLoad,
    input  logic                isStore,
    input  logic [DBITS-1:0]    dataAddr,
    input  logic [DBITS-1:0]    storeData,
    output logic                memReq,
    output logic                memWe,
    output logic [DBITS-1:0]    memAddr,
    output logic [DBITS-1:0]    memWdata,
    input  logic [DBITS-1:0]    memRdata,
    input  logic                memAck,
    output logic [DBITS-1:0]    instrWord,
    output logic [DBITS-1:0]    loadData,
    output logic                lock,
    output logic                busy,
    output logic                fault,
    output logic [CNT_BITS-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_COMMIT,
        S_FAULT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DBITS-1:0]    mem_addr_q, mem_addr_d;
    logic [DBITS-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DBITS-1:0]    instr_word_q, instr_word_d;
    logic [DBITS-1:0]    load_data_q, load_data_d;
    logic                lock_q, lock_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic [CNT_BITS-1:0] retired_q, retired_d;
    logic [7:0]          tmo_q, tmo_d;
    logic                ack;
    logic                tmo_hit;

    // An acknowledge only counts while a request is actually outstanding.
    assign ack     = memAck & mem_req_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        instr_word_d = instr_word_q;
        load_data_d  = load_data_q;
        lock_d       = 1'b0;
        retired_d    = retired_q;
        tmo_d        = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d    = S_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pcOut;
                    tmo_d      = '0;
                end
            end
            S_FETCH: begin
                if (ack) begin
                    instr_word_d = memRdata;
                    mem_req_d    = 1'b0;
                    state_d      = S_EXEC;
                end else if (tmo_hit) begin
                    state_d   = S_FAULT;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_EXEC: begin
                // Load and store together resolves to a store via mem_we_d.
                if (isLoad || isStore) begin
                    state_d    = S_DATA;
                    mem_req_d  = 1'b1;
                    mem_we_d   = isStore;
                    mem_addr_d = dataAddr;
                    if (isStore) begin
                        mem_wdata_d = storeData;
                    end
                    tmo_d = '0;
                end else begin
                    state_d   = S_COMMIT;
                    lock_d    = 1'b1;
                    retired_d = retired_q + CNT_BITS'(1);
                end
            end
            S_DATA: begin
                if (ack) begin
                    if (!mem_we_q) begin
                        load_data_d = memRdata;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_COMMIT;
                    lock_d    = 1'b1;
                    retired_d = retired_q + CNT_BITS'(1);
                end else if (tmo_hit) begin
                    state_d   = S_FAULT;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_COMMIT: begin
                if (run) begin
                    state_d    = S_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pcOut;
                    tmo_d      = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
        fault_d = fault_q | (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            instr_word_q <= '0;
            load_data_q  <= '0;
            lock_q       <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            retired_q    <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_word_q <= instr_word_d;
            load_data_q  <= load_data_d;
            lock_q       <= lock_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            retired_q    <= retired_d;
            tmo_q        <= tmo_d;
        end
    end

    assign memReq    = mem_req_q;
    assign memWe     = mem_we_q;
    assign memAddr   = mem_addr_q;
    assign memWdata  = mem_wdata_q;
    assign instrWord = instr_word_q;
    assign loadData  = load_data_q;
    assign lock      = lock_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_sc_mem_sequencer.sv
// Self-checking bench for sc_mem_sequencer: randomized memory waits and
// instruction mix checked against a transaction-level latency/memory model.
module tb_sc_mem_sequencer;

    localparam int unsigned DBITS    = 32;
    localparam int unsigned TIMEOUT  = 15;
    localparam int unsigned CNT_BITS = 32;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                run = 1'b0;
    logic                step = 1'b0;
    logic [DBITS-1:0]    pcOut = '0;
    logic                isLoad = 1'b0;
    logic                isStore = 1'b0;
    logic [DBITS-1:0]    dataAddr = '0;
    logic [DBITS-1:0]    storeData = '0;
    logic                memReq;
    logic                memWe;
    logic [DBITS-1:0]    memAddr;
    logic [DBITS-1:0]    memWdata;
    logic [DBITS-1:0]    memRdata = '0;
    logic                memAck = 1'b0;
    logic [DBITS-1:0]    instrWord;
    logic [DBITS-1:0]    loadData;
    logic                lock;
    logic                busy;
    logic                fault;
    logic [CNT_BITS-1:0] retired;

    always #5 clk = ~clk;

    sc_mem_sequencer #(.DBITS(DBITS), .TIMEOUT(TIMEOUT), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .pcOut(pcOut),
        .isLoad(isLoad), .isStore(isStore), .dataAddr(dataAddr), .storeData(storeData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck), .instrWord(instrWord), .loadData(loadData),
        .lock(lock), .busy(busy), .fault(fault), .retired(retired)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_load = '0;
    logic [31:0] exp_retired = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: per-request wait from wait_q (else random), logs transactions
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic [31:0] mem [logic [31:0]];
    int          wait_q[$];
    txn_t        txn_q[$];
    bit          resp_en = 1'b1;
    bit          spur_en = 1'b0;
    int          max_wait = 3;
    bit          active = 1'b0;
    int          cnt = 0;
    int          cur_wait = 0;
    logic [31:0] a0, d0;
    logic        w0;
    int          stab_err = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            active = 1'b0;
            memAck = 1'b0;
        end else if (memReq) begin
            if (!active) begin
                active = 1'b1;
                cnt = 0;
                cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : int'($urandom_range(0, max_wait));
                a0 = memAddr; w0 = memWe; d0 = memWdata;
            end else if (memAddr !== a0 || memWe !== w0 || memWdata !== d0) begin
                stab_err++;
            end
            if (resp_en && cnt == cur_wait) begin
                memAck = 1'b1;
                if (w0) begin
                    mem[a0] = d0;
                    memRdata = $urandom;
                end else begin
                    memRdata = mem.exists(a0) ? mem[a0] : init_word(a0);
                end
                txn_q.push_back('{a0, w0, d0});
            end else begin
                memAck = 1'b0;
                memRdata = $urandom;
                cnt++;
            end
        end else begin
            active = 1'b0;
            memAck = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            memRdata = $urandom;
        end
    end

    task automatic exec_instr(input logic [31:0] pc, input bit ld, input bit st,
                              input logic [31:0] da, input logic [31:0] sd, output int lat);
        @(negedge clk);
        pcOut = pc; isLoad = ld; isStore = st; dataAddr = da; storeData = sd; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        pcOut = ~pc;
        lat = 1;
        while (lock !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({memReq, memWe, lock, busy, fault} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {memReq, memWe, lock, busy, fault}); end
        checks++; if (memAddr !== '0 || memWdata !== '0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", memAddr, memWdata); end
        checks++; if (instrWord !== '0 || loadData !== '0) begin errors++; $display("FAIL reset_instr_load: got %h/%h want 0/0", instrWord, loadData); end
        checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
        reset_n = 1'b1;
        exp_retired = '0;
        exp_load = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || memReq !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b memReq=%b want 0/0", busy, memReq); end
    endtask

    task automatic test_alu_stream;
        int we_seen = 0;
        max_wait = 0;
        wait_q.delete();
        isLoad = 1'b0; isStore = 1'b0; pcOut = 32'h0000_0100;
        run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (memWe === 1'b1) we_seen++;
            checks++; if (lock !== ((i % 3) == 0)) begin errors++; $display("FAIL alu_lock_cycle%0d: got %b want %b", i, lock, (i % 3) == 0); end
        end
        exp_retired += 3;
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL alu_retired: got %0d want %0d", retired, exp_retired); end
        checks++; if (we_seen != 0) begin errors++; $display("FAIL alu_memwe: got %0d cycles with memWe want 0", we_seen); end
        run = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || lock !== 1'b0) begin errors++; $display("FAIL alu_halt: busy=%b lock=%b want 0/0", busy, lock); end
        max_wait = 3;
    endtask

    task automatic test_load_waits;
        int lat;
        mem[32'h10] = 32'h8C00_0004;
        mem[32'h40] = 32'hDEAD_BEEF;
        wait_q.delete(); txn_q.delete();
        wait_q.push_back(2); wait_q.push_back(1);
        exec_instr(32'h10, 1'b1, 1'b0, 32'h40, 32'h0, lat);
        exp_retired++;
        exp_load = 32'hDEAD_BEEF;
        checks++; if (lat != 7) begin errors++; $display("FAIL load_latency: got %0d want 7", lat); end
        checks++; if (instrWord !== 32'h8C00_0004) begin errors++; $display("FAIL load_instr: got %h want 8c000004", instrWord); end
        checks++; if (loadData !== exp_load) begin errors++; $display("FAIL load_data: got %h want %h", loadData, exp_load); end
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL load_retired: got %0d want %0d", retired, exp_retired); end
        checks++; if (txn_q.size() != 2 || txn_q[0].addr !== 32'h10 || txn_q[1].addr !== 32'h40 || txn_q[1].we !== 1'b0) begin
            errors++; $display("FAIL load_txns: got %0d txns want fetch@10 read@40", txn_q.size()); end
        @(negedge clk);
        checks++; if (lock !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL load_after_commit: lock=%b busy=%b want 0/0", lock, busy); end
    endtask

    task automatic test_store;
        int lat;
        wait_q.delete(); txn_q.delete();
        wait_q.push_back(0); wait_q.push_back(3);
        stab_err = 0;
        exec_instr(32'h20, 1'b0, 1'b1, 32'h80, 32'h1234_5678, lat);
        exp_retired++;
        ref_mem[32'h80] = 32'h1234_5678;
        checks++; if (lat != 7) begin errors++; $display("FAIL store_latency: got %0d want 7", lat); end
        checks++; if (txn_q.size() != 2 || txn_q[1].addr !== 32'h80 || txn_q[1].we !== 1'b1 || txn_q[1].wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL store_txn: got %0d txns want write 12345678@80", txn_q.size()); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL store_stable: got %0d changes while memReq want 0", stab_err); end
        checks++; if (loadData !== exp_load) begin errors++; $display("FAIL store_loaddata: got %h want %h", loadData, exp_load); end
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL store_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_single_step;
        int locks = 0;
        wait_q.delete();
        wait_q.push_back(1);
        @(negedge clk);
        isLoad = 1'b0; isStore = 1'b0; pcOut = 32'h200; step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        if (lock === 1'b1) locks++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lock === 1'b1) locks++;
        end
        exp_retired++;
        checks++; if (locks != 1) begin errors++; $display("FAIL step_locks: got %0d want 1", locks); end
        checks++; if (busy !== 1'b0 || memReq !== 1'b0) begin errors++; $display("FAIL step_idle: busy=%b memReq=%b want 0/0", busy, memReq); end
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL step_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_random;
        int lat, exp_lat, nexp, wf, wd, kind;
        bit ld, st;
        logic [31:0] pc, da, sd;
        spur_en = 1'b1;
        stab_err = 0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            ld = (kind == 1) || (kind == 3);
            st = (kind >= 2);
            pc = 32'h1000 + 4 * $urandom_range(0, 1023);
            da = 32'h100 + 4 * $urandom_range(0, 7);
            sd = $urandom;
            wf = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            wait_q.delete(); txn_q.delete();
            wait_q.push_back(wf);
            if (ld || st) wait_q.push_back(wd);
            exec_instr(pc, ld, st, da, sd, lat);
            exp_lat = 3 + wf + ((ld || st) ? wd + 1 : 0);
            nexp = (ld || st) ? 2 : 1;
            exp_retired++;
            if (st) ref_mem[da] = sd;
            else if (ld) exp_load = ref_mem.exists(da) ? ref_mem[da] : init_word(da);
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, exp_lat); end
            checks++; if (instrWord !== init_word(pc)) begin errors++; $display("FAIL rnd%0d_instr: got %h want %h", n, instrWord, init_word(pc)); end
            checks++; if (loadData !== exp_load) begin errors++; $display("FAIL rnd%0d_loaddata: got %h want %h", n, loadData, exp_load); end
            checks++; if (retired !== exp_retired) begin errors++; $display("FAIL rnd%0d_retired: got %0d want %0d", n, retired, exp_retired); end
            checks++; if (txn_q.size() != nexp) begin errors++; $display("FAIL rnd%0d_txn_count: got %0d want %0d", n, txn_q.size(), nexp); end
            else begin
                checks++; if (txn_q[0].addr !== pc || txn_q[0].we !== 1'b0) begin errors++; $display("FAIL rnd%0d_fetch: got %h/%b want %h/0", n, txn_q[0].addr, txn_q[0].we, pc); end
                if (nexp == 2) begin
                    checks++; if (txn_q[1].addr !== da || txn_q[1].we !== st || (st && txn_q[1].wdata !== sd)) begin
                        errors++; $display("FAIL rnd%0d_data: got %h/%b/%h want %h/%b/%h", n, txn_q[1].addr, txn_q[1].we, txn_q[1].wdata, da, st, sd); end
                end
            end
            @(negedge clk);
            checks++; if (lock !== 1'b0) begin errors++; $display("FAIL rnd%0d_lock_width: got %b want 0", n, lock); end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL rnd_stable: got %0d changes while memReq want 0", stab_err); end
        spur_en = 1'b0;
    endtask

    task automatic test_timeout;
        int n = 0;
        int req_seen = 0;
        resp_en = 1'b0;
        wait_q.delete();
        @(negedge clk);
        isLoad = 1'b0; isStore = 1'b0; pcOut = 32'h300; step = 1'b1;
        @(negedge clk); step = 1'b0;
        while (memReq === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != TIMEOUT) begin errors++; $display("FAIL timeout_req_cycles: got %0d want %0d", n, TIMEOUT); end
        checks++; if (fault !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_fault: fault=%b busy=%b want 1/0", fault, busy); end
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step = i[0];
            @(negedge clk);
            if (memReq === 1'b1) req_seen++;
        end
        run = 1'b0; step = 1'b0;
        checks++; if (req_seen != 0 || fault !== 1'b1 || retired !== exp_retired) begin
            errors++; $display("FAIL timeout_sticky: req=%0d fault=%b retired=%0d want 0/1/%0d", req_seen, fault, retired, exp_retired); end
        reset_n = 1'b0;
        @(negedge clk);
        exp_retired = '0; exp_load = '0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear: got %b want 0", fault); end
        reset_n = 1'b1;
        resp_en = 1'b1;
    endtask

    task automatic test_async_reset;
        int n = 0;
        int lat;
        wait_q.delete(); txn_q.delete();
        wait_q.push_back(0); wait_q.push_back(10);
        @(negedge clk);
        isLoad = 1'b1; isStore = 1'b0; pcOut = 32'h400; dataAddr = 32'h200; step = 1'b1;
        @(negedge clk); step = 1'b0;
        while (!(memReq === 1'b1 && memAddr === 32'h200) && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n >= 20) begin errors++; $display("FAIL areset_reach_data: got %0d cycles want <20", n); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({memReq, memWe, lock, fault, busy} !== 5'b0) begin errors++; $display("FAIL areset_flags: got %b want 00000", {memReq, memWe, lock, fault, busy}); end
        checks++; if (retired !== '0 || memAddr !== '0 || instrWord !== '0 || loadData !== '0) begin
            errors++; $display("FAIL areset_regs: retired=%0d addr=%h instr=%h load=%h want 0", retired, memAddr, instrWord, loadData); end
        wait_q.delete(); txn_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        exp_retired = '0; exp_load = '0;
        wait_q.push_back(0);
        exec_instr(32'h500, 1'b0, 1'b0, 32'h0, 32'h0, lat);
        exp_retired++;
        checks++; if (lat != 3) begin errors++; $display("FAIL areset_restart_latency: got %0d want 3", lat); end
        checks++; if (instrWord !== init_word(32'h500) || retired !== exp_retired) begin
            errors++; $display("FAIL areset_restart: instr=%h retired=%0d want %h/%0d", instrWord, retired, init_word(32'h500), exp_retired); end
        checks++; if (txn_q.size() != 1 || txn_q[0].addr !== 32'h500) begin errors++; $display("FAIL areset_restart_fetch: got %0d txns want fetch@500", txn_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_stream();
        test_load_waits();
        test_store();
        test_single_step();
        test_random();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_mem_sequencer.md
Name: sc_mem_sequencer

Overview:
Multi-cycle sequencer that time-shares one memory port between instruction fetch and load/store data access for the SC processor.
It fetches the instruction word and holds it for decode. It runs the data phase when decode flags a load or store, then pulses the commit strobe `lock` for one cycle, which gates register-file and memory write enables.
It also provides run/step/halt control, a retired-instruction counter, and a bus-timeout fault.

Parameters:
DBITS, 32, data/address width
TIMEOUT, 15, max cycles to wait for memAck before faulting (1..255)
CNT_BITS, 32, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
run  in  1  level: free-run instructions while high
step  in  1  single-cycle pulse: execute exactly one instruction from IDLE
pcOut  in  DBITS  current PC (fetch address)
isLoad  in  1  decode of instrWord: LW; valid in EXEC
isStore  in  1  decode of instrWord: SW; valid in EXEC
dataAddr  in  DBITS  ALU result used as data address; valid in EXEC
storeData  in  DBITS  store value; valid in EXEC
memReq  out  1  memory request
memWe  out  1  memory write enable, qualified by memReq
memAddr  out  DBITS  memory address
memWdata  out  DBITS  memory write data
memRdata  in  DBITS  memory read data, valid with memAck
memAck  in  1  memory completion
instrWord  out  DBITS  registered fetched instruction
loadData  out  DBITS  registered load result
lock  out  1  one-cycle commit strobe
busy  out  1  high in any state except IDLE and FAULT
fault  out  1  sticky bus-timeout flag
retired  out  CNT_BITS  count of committed instructions

Behaviour:
- All outputs are registered.
- Reset is asynchronous. Asserting reset_n low at any time, including mid-transaction:
  - state goes to IDLE;
  - memReq, memWe, lock, busy, fault go to 0;
  - memAddr, memWdata, instrWord, loadData, retired go to 0;
  - the timeout counter is cleared.
- States: IDLE, FETCH, EXEC, DATA, COMMIT, FAULT.
- IDLE:
  - Goes to FETCH when run=1 or step=1.
  - If both are high, they are treated as run.
  - A step pulse outside IDLE is ignored.
- FETCH:
  - Drives memReq=1, memWe=0, memAddr=pcOut (captured on entry, held stable).
  - On the first rising edge with memAck=1: instrWord<=memRdata, memReq<=0, go to EXEC.
- EXEC:
  - Exactly one cycle; memory idle.
  - If isLoad or isStore: go to DATA, registering memAddr<=dataAddr, memWe<=isStore, memWdata<=storeData (store only).
  - Otherwise go to COMMIT.
  - isLoad and isStore both high is illegal; it is treated as a store.
- DATA:
  - memReq=1, with address, write enable and write data held stable.
  - On memAck=1: for a load, loadData<=memRdata; memReq<=0, memWe<=0, go to COMMIT.
- COMMIT:
  - lock=1 for exactly this cycle.
  - retired increments by 1 and wraps modulo 2^CNT_BITS.
  - Next state: FETCH if run=1, else IDLE.
- Handshake rules:
  - memReq stays high until memAck is sampled high, then drops on the following cycle.
  - Zero-wait acknowledge (memAck already high in the first req cycle) is legal and completes that cycle.
  - memAck while memReq=0 is ignored.
  - Address, write enable and write data must not change while memReq=1.
- Timeout:
  - The counter resets to 0 on entry to FETCH or DATA and increments each cycle memReq=1 without ack.
  - Reaching TIMEOUT cycles without ack: go to FAULT, fault=1, memReq=0, memWe=0.
  - FAULT is terminal until reset; run and step are ignored there.
- Latency with zero-wait memory:
  - ALU instruction: 3 cycles (FETCH, EXEC, COMMIT).
  - Load/store: 4 cycles.
  - Each wait cycle adds 1.
- lock is never high outside COMMIT. A halt request (run dropping) takes effect only after the current COMMIT; in-flight instructions always complete.

Test Plan:
- ALU stream: run=1, zero-wait ack, isLoad=isStore=0 → lock pulses every 3rd cycle; retired=3 after 9 cycles; memWe never 1.
- Load with waits: pcOut=0x10, fetch ack after 2 waits returning 0x8C000004, isLoad=1, dataAddr=0x40, ack after 1 wait with memRdata=0xDEADBEEF → loadData=0xDEADBEEF, one lock pulse 7 cycles after start.
- Store: isStore=1, dataAddr=0x80, storeData=0x12345678 → memReq=1, memWe=1, memAddr=0x80, memWdata=0x12345678 held stable until ack; lock 1 cycle later.
- Single step: run=0, one step pulse → exactly one lock, then IDLE, busy=0; a second step while busy is ignored.
- Timeout: TIMEOUT=15, memAck held 0 → fault=1 after 15 req cycles, memReq=0; run/step have no effect until reset_n pulses low.
- Async reset mid-DATA with memReq=1 → memReq, lock, fault drop in the same cycle as reset_n falls; retired=0; restart fetches cleanly from pcOut.
